// File: rtl/input_port_unit_if.sv
// Link-side and allocator-side signals of one router input port.
// The slave modport is the input_port_unit view; the master modport is the upstream/allocator view.
interface input_port_unit_if #(
    parameter int DATASIZE = 40
);
    logic [DATASIZE-1:0] data_in;
    logic                data_valid;
    logic                full;
    logic                ready;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic [15:0]         stall_cnt;

    modport master (
        output data_in, data_valid, ready,
        input  full, label, data_out, stall_cnt
    );

    modport slave (
        input  data_in, data_valid, ready,
        output full, label, data_out, stall_cnt
    );
endinterface

// File: rtl/input_port_unit.sv
// Router input port: flit FIFO with XY route computation on the head flit.
// Optional head-blocked stall counter enabled by macro IPU_STALL_CNT_EN.
module input_port_unit #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int X_POS    = 0,
    parameter int Y_POS    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input_port_unit_if.slave   port_if
);
    localparam logic [1:0]     X_COORD   = 2'(X_POS);
    localparam logic [1:0]     Y_COORD   = 2'(Y_POS);
    localparam logic [WIDTH:0] CNT_FULL  = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH-1:0] PTR_LAST = WIDTH'(DEPTH - 1);

    logic [DATASIZE-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_r;
    logic [WIDTH-1:0]    rd_ptr_r;
    logic [WIDTH:0]      count_r;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [DATASIZE-1:0] head_s;

    // Pointer advance with explicit wrap so non-power-of-two depths also work.
    function automatic logic [WIDTH-1:0] next_ptr(input logic [WIDTH-1:0] ptr);
        logic [WIDTH-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {WIDTH{1'b0}};
        end else begin
            nxt = ptr + WIDTH'(1);
        end
        return nxt;
    endfunction

    // Dimension-ordered routing: resolve X first, then Y (rows increase southward).
    function automatic logic [3:0] route_label(input logic [3:0] dst);
        logic [3:0] lbl;
        if (dst[1:0] > X_COORD) begin
            lbl = 4'b0010;
        end else if (dst[1:0] < X_COORD) begin
            lbl = 4'b1000;
        end else if (dst[3:2] > Y_COORD) begin
            lbl = 4'b0001;
        end else if (dst[3:2] < Y_COORD) begin
            lbl = 4'b0100;
        end else begin
            lbl = 4'b0000;
        end
        return lbl;
    endfunction

    assign empty_s = (count_r == {(WIDTH+1){1'b0}});
    assign full_s  = (count_r == CNT_FULL);
    assign push_s  = port_if.data_valid & ~full_s;
    assign pop_s   = port_if.ready & ~empty_s;
    assign head_s  = mem_r[rd_ptr_r];

    // Flit storage; contents are left as-is on reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= port_if.data_in;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {WIDTH{1'b0}};
            rd_ptr_r <= {WIDTH{1'b0}};
            count_r  <= {(WIDTH+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (WIDTH+1)'(1);
                2'b01:   count_r <= count_r - (WIDTH+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-side outputs; an empty FIFO presents the all-ones label and a zero flit.
    always_comb begin
        port_if.full     = full_s;
        port_if.label    = 4'b1111;
        port_if.data_out = {DATASIZE{1'b0}};
        if (empty_s) begin
            port_if.label    = 4'b1111;
            port_if.data_out = {DATASIZE{1'b0}};
        end else begin
            port_if.label    = route_label(head_s[35:32]);
            port_if.data_out = head_s;
        end
    end

`ifdef IPU_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count cycles the head flit waits on the allocator, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (!empty_s && !port_if.ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign port_if.stall_cnt = stall_cnt_r;
`else
    assign port_if.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// Directed self-checking bench for input_port_unit at router position (1,1).
module tb_input_port_unit;
    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   errors_cnt;

    input_port_unit_if #(.DATASIZE(40)) port_if ();

    input_port_unit #(
        .DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_POS(1), .Y_POS(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_if (port_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] make_flit(input logic [3:0] dst, input logic [21:0] payload);
        return {4'hA, dst, payload[7:0], payload, 2'b01};
    endfunction

    logic [39:0] f;
    logic [39:0] exp_q[$];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n = 1'b0;
        port_if.data_in    = 40'h0;
        port_if.data_valid = 1'b0;
        port_if.ready      = 1'b0;
        #3;
        check_val("rst_label", 64'(port_if.label), 64'hF);
        check_val("rst_full", 64'(port_if.full), 64'h0);
        check_val("rst_data", 64'(port_if.data_out), 64'h0);
        check_val("rst_stall", 64'(port_if.stall_cnt), 64'h0);
        #5 rst_n = 1'b1;
        step();

        // ready while empty must be ignored
        port_if.ready = 1'b1;
        step();
        check_val("empty_pop_label", 64'(port_if.label), 64'hF);
        port_if.ready = 1'b0;

        // single flit routed east
        f = make_flit(4'b0111, 22'h12345);
        port_if.data_in = f;
        port_if.data_valid = 1'b1;
        step();
        port_if.data_valid = 1'b0;
        check_val("east_label", 64'(port_if.label), 64'h2);
        check_val("east_data", 64'(port_if.data_out), 64'(f));
        port_if.ready = 1'b1;
        step();
        port_if.ready = 1'b0;
        check_val("east_pop_label", 64'(port_if.label), 64'hF);
        check_val("east_pop_data", 64'(port_if.data_out), 64'h0);

        // north, south, local in order
        port_if.data_valid = 1'b1;
        port_if.data_in = make_flit(4'b0001, 22'h1);
        step();
        port_if.data_in = make_flit(4'b1001, 22'h2);
        step();
        port_if.data_in = make_flit(4'b0101, 22'h3);
        step();
        port_if.data_valid = 1'b0;
        check_val("north_label", 64'(port_if.label), 64'h4);
        port_if.ready = 1'b1;
        step();
        check_val("south_label", 64'(port_if.label), 64'h1);
        step();
        check_val("local_label", 64'(port_if.label), 64'h0);
        check_val("local_data", 64'(port_if.data_out), 64'(make_flit(4'b0101, 22'h3)));
        step();
        port_if.ready = 1'b0;
        check_val("nsl_empty_label", 64'(port_if.label), 64'hF);

        // fill to full, drop ninth, drain in order
        port_if.data_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val("fill_not_full", 64'(port_if.full), 64'h0);
            port_if.data_in = make_flit(4'b0101, 22'(i));
            step();
        end
        check_val("fill_full", 64'(port_if.full), 64'h1);
        port_if.data_in = make_flit(4'b0101, 22'd9);
        step();
        port_if.data_valid = 1'b0;
        check_val("drop_full", 64'(port_if.full), 64'h1);
        port_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val("drain_order", 64'(port_if.data_out), 64'(make_flit(4'b0101, 22'(i))));
            step();
            if (i == 1) begin
                check_val("drain_not_full", 64'(port_if.full), 64'h0);
            end
        end
        port_if.ready = 1'b0;
        check_val("drain_empty", 64'(port_if.label), 64'hF);

        // three stored, then push and pop together for ten cycles
        port_if.data_valid = 1'b1;
        for (int i = 20; i < 23; i++) begin
            port_if.data_in = make_flit(4'b0110, 22'(i));
            exp_q.push_back(make_flit(4'b0110, 22'(i)));
            step();
        end
        port_if.ready = 1'b1;
        for (int i = 23; i < 33; i++) begin
            f = exp_q.pop_front();
            check_val("stream_head", 64'(port_if.data_out), 64'(f));
            port_if.data_in = make_flit(4'b0110, 22'(i));
            exp_q.push_back(make_flit(4'b0110, 22'(i)));
            step();
        end
        port_if.data_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f = exp_q.pop_front();
            check_val("stream_tail", 64'(port_if.data_out), 64'(f));
            step();
        end
        port_if.ready = 1'b0;
        check_val("stream_empty", 64'(port_if.label), 64'hF);

        // reset in the middle of a burst
        port_if.data_valid = 1'b1;
        for (int i = 40; i < 45; i++) begin
            port_if.data_in = make_flit(4'b0111, 22'(i));
            step();
        end
        port_if.data_valid = 1'b0;
        check_val("pre_rst_label", 64'(port_if.label), 64'h2);
        rst_n = 1'b0;
        #1;
        check_val("midrst_label", 64'(port_if.label), 64'hF);
        check_val("midrst_full", 64'(port_if.full), 64'h0);
        check_val("midrst_data", 64'(port_if.data_out), 64'h0);
        #2 rst_n = 1'b1;
        f = make_flit(4'b1101, 22'h3ABCD);
        port_if.data_in = f;
        port_if.data_valid = 1'b1;
        step();
        port_if.data_valid = 1'b0;
        check_val("postrst_head", 64'(port_if.data_out), 64'(f));
        check_val("postrst_label", 64'(port_if.label), 64'h1);

        // hold the head for twenty cycles
        for (int k = 0; k < 20; k++) begin
            step();
        end
`ifdef IPU_STALL_CNT_EN
        check_val("stall_cnt", 64'(port_if.stall_cnt), 64'd20);
`else
        check_val("stall_cnt", 64'(port_if.stall_cnt), 64'd0);
`endif
        check_val("stall_head", 64'(port_if.data_out), 64'(f));

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
